spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 123 ++++++++++++
 tb/tb_spi_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master: one DATA_WIDTH-bit full-duplex transfer per accepted start.
// SCLK runs at clk/(2*PRESCALE), and CPOL/CPHA select the SPI mode.
// Every output is registered. The cycle after start is accepted only loads
// the word, so busy/CS/MOSI come up one clk after the accepting edge.
module spi_master #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 4,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic                  CS
);

    localparam int CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PRESCALE - 1);
    // edge_idx counts SCLK toggles already made. When it reaches 2*DATA_WIDTH,
    // the next tick ends the transfer instead of toggling SCLK.
    localparam logic [EDGE_W-1:0] EDGE_DONE = EDGE_W'(2 * DATA_WIDTH);
    localparam logic [EDGE_W-1:0] EDGE_PEN  = EDGE_W'(2 * DATA_WIDTH - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t                state;
    logic                  launch;
    logic [CNT_W-1:0]      cnt;
    logic [EDGE_W-1:0]     edge_idx;
    logic [DATA_WIDTH-1:0] tx;
    logic [DATA_WIDTH-1:0] rx;

    logic tick;
    logic leading;
    logic sample_now;
    logic shift_now;

    // Decode the next SCLK event: odd-numbered toggles (even edge_idx) are leading edges.
    always_comb begin
        tick       = (cnt == CNT_LAST);
        leading    = ~edge_idx[0];
        sample_now = leading ^ CPHA;
        shift_now  = 1'b0;
        if (CPHA) begin
            shift_now = leading && (edge_idx != '0);
        end else begin
            shift_now = !leading && (edge_idx != EDGE_PEN);
        end
    end

    // Transfer FSM. It owns the prescaler, edge counter, shift registers and all outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            launch   <= 1'b0;
            cnt      <= '0;
            edge_idx <= '0;
            tx       <= '0;
            rx       <= '0;
            data_out <= '0;
            busy     <= 1'b0;
            CS       <= 1'b1;
            SCLK     <= CPOL;
            MOSI     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= XFER;
                        launch   <= 1'b1;
                        tx       <= data_in;
                        rx       <= '0;
                        cnt      <= '0;
                        edge_idx <= '0;
                    end
                end
                XFER: begin
                    if (launch) begin
                        // Present the MSB before any SCLK edge, as CPHA=0 slaves require.
                        launch <= 1'b0;
                        busy   <= 1'b1;
                        CS     <= 1'b0;
                        MOSI   <= tx[DATA_WIDTH-1];
                        cnt    <= '0;
                    end else if (!tick) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (edge_idx == EDGE_DONE) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            CS       <= 1'b1;
                            MOSI     <= 1'b0;
                            data_out <= rx;
                            tx       <= '0;
                            edge_idx <= '0;
                        end else begin
                            SCLK     <= ~SCLK;
                            edge_idx <= edge_idx + 1'b1;
                            if (sample_now) begin
                                rx <= {rx[DATA_WIDTH-2:0], MISO};
                            end
                            if (shift_now) begin
                                MOSI <= tx[DATA_WIDTH-2];
                                tx   <= {tx[DATA_WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master. Four instances (SPI modes 0..3) share one stimulus.
// Per-mode monitors pop expected words when busy falls and check the result.
module tb_spi_master;

    localparam int DW       = 8;
    localparam int PS       = 4;
    localparam int BUSY_LEN = (2 * DW + 1) * PS;   // 68
    localparam int TIMEOUT  = 400;

    typedef struct packed {
        logic [7:0] dout;
        logic [7:0] tx;
    } exp_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       start    = 1'b0;
    logic [7:0] data_in  = 8'h00;
    logic       miso_one = 1'b0;

    logic       busy_w [4];
    logic       sclk_w [4];
    logic       mosi_w [4];
    logic       cs_w   [4];
    logic [7:0] dout_w [4];

    exp_t exp_q [4][$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    for (genvar m = 0; m < 4; m++) begin : g_mode
        localparam bit M_CPOL = (m >= 2);
        localparam bit M_CPHA = ((m % 2) == 1);

        logic miso;
        assign miso = miso_one ? 1'b1 : mosi_w[m];

        spi_master #(
            .DATA_WIDTH(DW),
            .PRESCALE  (PS),
            .CPOL      (M_CPOL),
            .CPHA      (M_CPHA)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start),
            .data_in (data_in),
            .data_out(dout_w[m]),
            .busy    (busy_w[m]),
            .SCLK    (sclk_w[m]),
            .MOSI    (mosi_w[m]),
            .MISO    (miso),
            .CS      (cs_w[m])
        );

        // Monitor: collect MOSI at this mode's sampling edges and time busy; check when busy falls.
        initial begin
            logic       prev_busy;
            logic       prev_sclk;
            int         blen;
            int         nlead;
            int         first_lead;
            logic [7:0] cap;
            exp_t       e;
            prev_busy  = 1'b0;
            prev_sclk  = M_CPOL;
            blen       = 0;
            nlead      = 0;
            first_lead = 0;
            cap        = 8'h00;
            forever begin
                @(negedge clk);
                if (!rst) begin
                    prev_busy = 1'b0;
                    prev_sclk = sclk_w[m];
                    continue;
                end
                if (busy_w[m] && !prev_busy) begin
                    blen       = 0;
                    nlead      = 0;
                    first_lead = 0;
                    cap        = 8'h00;
                    check($sformatf("m%0d_sclk_idle_before", m), sclk_w[m], M_CPOL);
                    check($sformatf("m%0d_cs_low", m), cs_w[m], 1'b0);
                end
                if (busy_w[m]) begin
                    blen++;
                    if (sclk_w[m] != prev_sclk) begin
                        if (sclk_w[m] != M_CPOL) begin
                            nlead++;
                            if (nlead == 1) first_lead = blen;
                        end
                        if ((sclk_w[m] != M_CPOL) ^ M_CPHA) cap = {cap[6:0], mosi_w[m]};
                    end
                end
                if (!busy_w[m] && prev_busy) begin
                    if (exp_q[m].size() == 0) begin
                        check($sformatf("m%0d_unexpected_xfer", m), 1, 0);
                    end else begin
                        e = exp_q[m].pop_front();
                        check($sformatf("m%0d_data_out", m), dout_w[m], e.dout);
                        check($sformatf("m%0d_mosi_bits", m), cap, e.tx);
                        check($sformatf("m%0d_busy_len", m), blen, BUSY_LEN);
                        check($sformatf("m%0d_lead_edges", m), nlead, DW);
                        check($sformatf("m%0d_first_lead_at", m), first_lead, PS + 1);
                        check($sformatf("m%0d_sclk_idle_after", m), sclk_w[m], M_CPOL);
                        check($sformatf("m%0d_cs_high_after", m), cs_w[m], 1'b1);
                        check($sformatf("m%0d_mosi_low_after", m), mosi_w[m], 1'b0);
                    end
                end
                prev_busy = busy_w[m];
                prev_sclk = sclk_w[m];
            end
        end
    end

    task automatic push(input logic [7:0] dout, input logic [7:0] tx);
        exp_t e;
        e.dout = dout;
        e.tx   = tx;
        for (int m = 0; m < 4; m++) exp_q[m].push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy_w[0] && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ends"}, busy_w[0], 1'b0);
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (!busy_w[0] && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check({name, "_starts"}, busy_w[0], 1'b1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] d);
        @(negedge clk);
        data_in = d;
        start   = 1'b1;
        @(posedge clk);
        #1 check("accept_edge_busy_low", busy_w[0], 1'b0);
        @(posedge clk);
        #1 check("busy_after_accept", busy_w[0], 1'b1);
        check("cs_after_accept", cs_w[0], 1'b0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_state(input string name);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("%s_m%0d_busy", name, m), busy_w[m], 1'b0);
            check($sformatf("%s_m%0d_cs", name, m), cs_w[m], 1'b1);
            check($sformatf("%s_m%0d_sclk", name, m), sclk_w[m], (m >= 2));
            check($sformatf("%s_m%0d_mosi", name, m), mosi_w[m], 1'b0);
            check($sformatf("%s_m%0d_dout", name, m), dout_w[m], 8'h00);
        end
    endtask

    initial begin
        // Power-on reset
        idle_cycles(3);
        check_reset_state("reset");
        rst = 1'b1;
        idle_cycles(3);

        // Loopback words in all four modes
        push(8'hAC, 8'hAC);
        xfer(8'hAC);
        wait_idle("xfer_ac");
        idle_cycles(10);
        for (int m = 0; m < 4; m++) check($sformatf("hold_ac_m%0d", m), dout_w[m], 8'hAC);

        push(8'h5A, 8'h5A);
        xfer(8'h5A);
        wait_idle("xfer_5a");
        idle_cycles(4);

        push(8'hC3, 8'hC3);
        xfer(8'hC3);
        wait_idle("xfer_c3");
        idle_cycles(4);

        // MISO tied high while sending zero
        miso_one = 1'b1;
        push(8'hFF, 8'h00);
        xfer(8'h00);
        wait_idle("xfer_miso1");
        idle_cycles(4);
        miso_one = 1'b0;

        // A start and data_in change during a transfer are ignored
        push(8'h3C, 8'h3C);
        xfer(8'h3C);
        idle_cycles(20);
        start   = 1'b1;
        data_in = 8'hFF;
        @(negedge clk);
        start   = 1'b0;
        idle_cycles(10);
        data_in = 8'h00;
        wait_idle("xfer_ignore");
        idle_cycles(5);
        check("no_restart_after_ignore", busy_w[0], 1'b0);
        for (int m = 0; m < 4; m++) check($sformatf("hold_3c_m%0d", m), dout_w[m], 8'h3C);

        // A start held through busy falling launches the next word
        push(8'h96, 8'h96);
        push(8'h69, 8'h69);
        @(negedge clk);
        data_in = 8'h96;
        start   = 1'b1;
        wait_busy("b2b_first");
        idle_cycles(2);
        data_in = 8'h69;
        wait_idle("b2b_first");
        wait_busy("b2b_second");
        start = 1'b0;
        wait_idle("b2b_second");
        idle_cycles(4);

        // Reset part-way through a transfer
        xfer(8'hF0);
        idle_cycles(4 * 2 * PS);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_reset_state("midreset");
        idle_cycles(2);
        rst = 1'b1;
        idle_cycles(3);
        push(8'h81, 8'h81);
        xfer(8'h81);
        wait_idle("xfer_81");
        idle_cycles(5);

        for (int m = 0; m < 4; m++) check($sformatf("m%0d_queue_drained", m), exp_q[m].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
